// File: rtl/moddiv_pkg.sv
// rtl/moddiv_pkg.sv - shared constants and FSM state type for the moddiv arbiter, core and bench
package moddiv_pkg;

    // 256-bit field element plus 2 guard bits, as used inside the core.
    localparam int MODDIV_W = 258;

    // Default watchdog limit (cycles spent waiting on the core).
    localparam int MODDIV_TIMEOUT = 4096;

    // Arbiter FSM encoding; explicit values keep waveforms comparable with older builds.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } moddiv_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Ports:
//   req       in  N_REQ  request vector
//   ptr       in  IW     highest-priority index for this round
//   en        in  1      picker enable; all outputs 0 when low
//   gnt       out N_REQ  one-hot grant (zero when nothing granted)
//   gnt_idx   out IW     index of the granted bit
//   gnt_valid out 1      a grant was made
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_valid
);

    int          j;
    logic [IW-1:0] jj;

    // Walk ptr, ptr+1, ... modulo N_REQ; the first set request wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        jj        = '0;
        if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                j  = (int'(ptr) + k) % N_REQ;
                jj = IW'(j);
                if (!gnt_valid && req[jj]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = jj;
                    gnt[jj]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/moddiv_arbiter.sv
// rtl/moddiv_arbiter.sv - round-robin sharing of one modular divider core between N_REQ requesters
// Optional watchdog: define MODDIV_ARB_TIMEOUT_EN to abort a core that runs past TIMEOUT cycles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready  [N_REQ]  request handshake (ready one-hot, IDLE only)
//   req_a/req_b/req_p [N_REQ*W]   per-requester operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready  [N_REQ]  response handshake (valid one-hot to the granted requester)
//   rsp_data [W], rsp_err         shared quotient bus and reject/abort flag
//   core_start, core_a/b/p [W]    start pulse and registered operands to the core
//   core_done, core_result [W]    completion pulse and result from the core
//   core_abort                    watchdog abort pulse (0 unless MODDIV_ARB_TIMEOUT_EN)
module moddiv_arbiter
    import moddiv_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = MODDIV_W,
    parameter int TIMEOUT = MODDIV_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*W-1:0] req_p,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic               rsp_err,
    output logic               core_start,
    output logic [W-1:0]       core_a,
    output logic [W-1:0]       core_b,
    output logic [W-1:0]       core_p,
    input  logic               core_done,
    input  logic [W-1:0]       core_result,
    output logic               core_abort
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    moddiv_state_e state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [W-1:0]  core_a_q, core_a_d;
    logic [W-1:0]  core_b_q, core_b_d;
    logic [W-1:0]  core_p_q, core_p_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic             arb_en;

    logic [W-1:0]     sel_a, sel_b, sel_p;
    logic             operands_bad;
    logic [N_REQ-1:0] grant_oh;

`ifdef MODDIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_hit;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

    // Gating with rst keeps a requester from seeing a handshake during the reset cycle.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .en        (arb_en),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign sel_a = req_a[arb_idx*W +: W];
    assign sel_b = req_b[arb_idx*W +: W];
    assign sel_p = req_p[arb_idx*W +: W];

    // The binary algorithm needs an invertible a and an odd modulus; reject otherwise.
    assign operands_bad = (sel_a == '0) || !sel_p[0];

    assign grant_oh = N_REQ'(1) << grant_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        core_a_d   = core_a_q;
        core_b_d   = core_b_q;
        core_p_d   = core_p_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef MODDIV_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_idx;
                    core_a_d = sel_a;
                    core_b_d = sel_b;
                    core_p_d = sel_p;
                    if (operands_bad) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
`ifdef MODDIV_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done on the timeout cycle takes priority over the abort.
                if (core_done) begin
                    rsp_data_d = core_result;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end
`ifdef MODDIV_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready[grant_q]) begin
                    rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            core_a_q   <= '0;
            core_b_q   <= '0;
            core_p_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef MODDIV_ARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            core_a_q   <= core_a_d;
            core_b_q   <= core_b_d;
            core_p_q   <= core_p_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef MODDIV_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign req_ready  = arb_gnt;
    assign rsp_valid  = ((state_q == ST_RESP) && !rst) ? grant_oh : '0;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign core_start = (state_q == ST_START) && !rst;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_p     = core_p_q;

`ifdef MODDIV_ARB_TIMEOUT_EN
    assign core_abort = (state_q == ST_WAIT) && !core_done && timeout_hit && !rst;
`else
    assign core_abort = 1'b0;
`endif

endmodule

// File: tb/tb_moddiv_arbiter.sv
// tb/tb_moddiv_arbiter.sv - directed self-checking bench for moddiv_arbiter
module tb_moddiv_arbiter;
    import moddiv_pkg::*;

    localparam int N = 4;
    localparam int W = MODDIV_W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N*W-1:0] req_p = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           core_start;
    logic [W-1:0]   core_a, core_b, core_p;
    logic           core_done = 1'b0;
    logic [W-1:0]   core_result = '0;
    logic           core_abort;

    int checks   = 0;
    int failures = 0;

    int         core_lat  = 1;
    bit         core_hang = 1'b0;
    logic [W-1:0] core_ret = '0;
    int         core_cnt  = 0;
    int         start_cnt = 0;
    int         abort_cnt = 0;

    moddiv_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_p       (req_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .core_start  (core_start),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_p      (core_p),
        .core_done   (core_done),
        .core_result (core_result),
        .core_abort  (core_abort)
    );

    always #5 clk = ~clk;

    // Core stand-in: done pulse core_lat WAIT cycles after start, returning core_ret.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst) begin
            core_cnt = 0;
        end else begin
            if (core_cnt != 0) begin
                core_cnt--;
                if (core_cnt == 0 && !core_hang) begin
                    core_done   = 1'b1;
                    core_result = core_ret;
                end
            end
            if (core_start) core_cnt = core_lat;
        end
    end

    always @(posedge clk) begin
        if (core_start) start_cnt++;
        if (core_abort) abort_cnt++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_p[i*W +: W] = p;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid === '0 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
        checks++; if (core_a !== '0 || core_b !== '0 || core_p !== '0) begin failures++; $display("FAIL reset_core_ops got=%h/%h/%h exp=0", core_a, core_b, core_p); end
        checks++; if (core_abort !== 1'b0) begin failures++; $display("FAIL reset_core_abort got=%b exp=0", core_abort); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_gated got=%b exp=0000", req_ready); end
        req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single;
        int  n;
        bit  ok;
        set_req(0, 258'd3, 258'd5, 258'd11);
        core_ret  = 258'd9;
        core_lat  = 3;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_req_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL single_core_start got=%b exp=1", core_start); end
        checks++; if (core_a !== 258'd3 || core_b !== 258'd5 || core_p !== 258'd11) begin failures++; $display("FAIL single_core_ops got=%0d/%0d/%0d exp=3/5/11", core_a, core_b, core_p); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_busy got=%b exp=0000", req_ready); end
        wait_rsp(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", n); end
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 258'd9 || rsp_err !== 1'b0) begin failures++; $display("FAIL single_rsp got=%b/%0d/%b exp=0001/9/0", rsp_valid, rsp_data, rsp_err); end
        ok = 1'b1;
        repeat (5) begin
            step();
            if (rsp_valid !== 4'b0001 || rsp_data !== 258'd9 || rsp_err !== 1'b0) ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL single_hold got=%b/%0d exp=0001/9", rsp_valid, rsp_data); end
        rsp_ready = 4'b0010;
        step();
        checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_wrong_ready got=%b exp=0001", rsp_valid); end
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", rsp_valid); end
    endtask

    task automatic test_inversion;
        int n;
        logic [W-1:0] ba, bb, bp, br;
        ba = {2'b10, {64{4'hA}}};
        bb = {2'b01, {64{4'h5}}};
        bp = {2'b11, {63{4'hF}}, 4'h1};
        br = {2'b10, {64{4'hC}}};
        set_req(1, 258'd3, 258'd1, 258'd11);
        core_ret  = 258'd4;
        core_lat  = 1;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL inv_req_ready got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        wait_rsp(n);
        checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 258'd4 || rsp_err !== 1'b0) begin failures++; $display("FAIL inv_rsp got=%b/%0d/%b exp=0010/4/0", rsp_valid, rsp_data, rsp_err); end
        rsp_ready = 4'b0010;
        step();
        rsp_ready = '0;
        set_req(3, ba, bb, bp);
        core_ret  = br;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wide_req_ready got=%b exp=1000", req_ready); end
        step();
        req_valid = '0;
        checks++; if (core_a !== ba || core_b !== bb || core_p !== bp) begin failures++; $display("FAIL wide_core_ops got=%h/%h/%h", core_a, core_b, core_p); end
        wait_rsp(n);
        checks++; if (rsp_valid !== 4'b1000 || rsp_data !== br) begin failures++; $display("FAIL wide_rsp got=%b/%h exp=1000/%h", rsp_valid, rsp_data, br); end
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;
    endtask

    task automatic test_errors;
        int s;
        s = start_cnt;
        set_req(0, 258'd0, 258'd5, 258'd11);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL err_a0_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL err_a0_start got=%b exp=0", core_start); end
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== '0) begin failures++; $display("FAIL err_a0_rsp got=%b/%b/%h exp=0001/1/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
        set_req(2, 258'd3, 258'd5, 258'd10);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL err_peven_ready got=%b exp=0100", req_ready); end
        step();
        req_valid = '0;
        checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL err_peven_start got=%b exp=0", core_start); end
        checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== '0) begin failures++; $display("FAIL err_peven_rsp got=%b/%b/%h exp=0100/1/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;
        step();
        checks++; if (start_cnt !== s) begin failures++; $display("FAIL err_no_start got=%0d exp=%0d", start_cnt - s, 0); end
    endtask

    task automatic test_round_robin;
        int n;
        logic [N-1:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 258'd3, 258'd5, 258'd11);
        core_ret  = 258'd9;
        core_lat  = 2;
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp = 4'b0001 << (g % 4);
            n = 0;
            while (req_ready === '0 && n < 20) begin
                step();
                n++;
            end
            checks++; if (req_ready !== exp || n !== 0) begin failures++; $display("FAIL rr_grant%0d got=%b wait=%0d exp=%b wait=0", g, req_ready, n, exp); end
            step();
            wait_rsp(n);
            checks++; if (rsp_valid !== exp || rsp_data !== 258'd9) begin failures++; $display("FAIL rr_rsp%0d got=%b/%0d exp=%b/9", g, rsp_valid, rsp_data, exp); end
            rsp_ready = exp;
            step();
            rsp_ready = '0;
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid;
        int n;
        core_hang = 1'b1;
        set_req(1, 258'd3, 258'd5, 258'd11);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        step();
        rst = 1'b1;
        step();
        checks++; if (req_ready !== '0 || rsp_valid !== '0 || core_start !== 1'b0 || core_abort !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b/%b/%b/%b exp=0", req_ready, rsp_valid, core_start, core_abort); end
        checks++; if (rsp_data !== '0 || rsp_err !== 1'b0 || core_a !== '0 || core_b !== '0 || core_p !== '0) begin failures++; $display("FAIL rstmid_data got=%h/%b/%h exp=0", rsp_data, rsp_err, core_a); end
        rst = 1'b0;
        core_hang = 1'b0;
        core_lat  = 1;
        core_ret  = 258'd4;
        set_req(2, 258'd3, 258'd1, 258'd11);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rstmid_ready got=%b exp=0100", req_ready); end
        step();
        req_valid = '0;
        wait_rsp(n);
        checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 258'd4 || rsp_err !== 1'b0) begin failures++; $display("FAIL rstmid_rsp got=%b/%0d/%b exp=0100/4/0", rsp_valid, rsp_data, rsp_err); end
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;
    endtask

`ifdef MODDIV_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        bit found;
        bit abort_seen;
        int done_at;
        core_hang = 1'b1;
        set_req(0, 258'd3, 258'd5, 258'd11);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        n = 1;
        found = 1'b0;
        while (!found && n < 100) begin
            @(negedge clk);
            #1;
            if (core_abort === 1'b1) found = 1'b1;
            else begin
                step();
                n++;
            end
        end
        checks++; if (!found || n !== 16) begin failures++; $display("FAIL to_abort_cycle got=%0d found=%b exp=16", n, found); end
        step();
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== '0) begin failures++; $display("FAIL to_rsp got=%b/%b/%h exp=0001/1/0", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
        core_hang = 1'b0;
        core_lat  = 16;
        core_ret  = 258'd9;
        set_req(1, 258'd3, 258'd5, 258'd11);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        abort_seen = 1'b0;
        done_at    = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            if (core_abort === 1'b1) abort_seen = 1'b1;
            if (core_done === 1'b1) done_at = k;
            if (k < 16) step();
        end
        step();
        checks++; if (abort_seen || done_at !== 16) begin failures++; $display("FAIL to_race got abort=%b done_at=%0d exp abort=0 done_at=16", abort_seen, done_at); end
        checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_data !== 258'd9) begin failures++; $display("FAIL to_race_rsp got=%b/%b/%0d exp=0010/0/9", rsp_valid, rsp_err, rsp_data); end
        rsp_ready = 4'b0010;
        step();
        rsp_ready = '0;
        step();
        checks++; if (abort_cnt !== 1) begin failures++; $display("FAIL to_abort_count got=%0d exp=1", abort_cnt); end
    endtask
`else
    task automatic test_no_abort;
        step();
        checks++; if (abort_cnt !== 0) begin failures++; $display("FAIL no_abort_count got=%0d exp=0", abort_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_inversion();
        test_errors();
        test_round_robin();
        test_reset_mid();
`ifdef MODDIV_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/moddiv_arbiter.md
Name: moddiv_arbiter

Overview:
- Shares one binary-algorithm modular divider core (computes b/a mod p) between N_REQ requesters.
- Round-robin arbitration; per-requester valid/ready on the request and response sides.
- Latches the winner's operands, pulses the core start, collects the result and routes it back to the winner.
- Sits between the ECC point-arithmetic sequencers and the moddiv core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 258, operand/result width; 256-bit field plus 2 guard bits, matching the core.
- TIMEOUT, 4096, watchdog limit in cycles. Used only with MODDIV_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  request valid, one bit per requester
- req_ready  out  N_REQ  request accepted; one-hot or zero
- req_a  in  N_REQ*W  divisor a, requester i at slice [i*W +: W]
- req_b  in  N_REQ*W  dividend b
- req_p  in  N_REQ*W  modulus p
- rsp_valid  out  N_REQ  response valid; one-hot or zero
- rsp_ready  in  N_REQ  response accepted
- rsp_data  out  W  quotient b*a^-1 mod p, shared bus
- rsp_err  out  1  request rejected or aborted
- core_start  out  1  one-cycle start pulse to the core
- core_a, core_b, core_p  out  W  registered operands to the core
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  W  core result, valid while core_done is high
- core_abort  out  1  one-cycle core abort (MODDIV_ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0. All outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_a/b/p, core_abort.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, … mod N_REQ.
  - Same cycle: req_ready[winner]=1 (combinational from state and req_valid), latch winner's operands into core_a/b/p, grant=winner.
  - If a==0 or p[0]==0: next state RESP with err=1, data=0; the core is never started.
  - Otherwise: next state START.
  - No req_valid: remain in IDLE.
- START: core_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - On core_done: rsp_data<=core_result, rsp_err<=0, then RESP.
  - core_done seen in any other state is ignored.
- RESP:
  - rsp_valid[grant]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[grant]: rr_ptr<=(grant+1) mod N_REQ, then IDLE.
  - rsp_ready on other bits is ignored.
- Best-case accept-to-response latency: 2 cycles + core latency (IDLE→START→WAIT; rsp_valid rises the cycle after core_done).
- Next grant is possible the cycle after the response handshake; no back-to-back acceptance while busy.
- req_ready is 0 in every state except IDLE.
- Requesters must hold req_valid and operands stable until req_ready.
- Dropping req_valid before grant is legal; the request is simply not taken.
- Fairness: a requester that is continuously valid is served within N_REQ grants.
- Reset mid-operation (any state): immediate return to reset values. No core_start or rsp_valid is emitted. The core is reset by the same rst.

Optional Feature:
- Macro: MODDIV_ARB_TIMEOUT_EN.
- With macro:
  - Cycle counter cleared in START, incremented in WAIT.
  - Reaching TIMEOUT in WAIT without core_done: core_abort=1 for one cycle, rsp_err<=1, rsp_data<=0, then RESP.
  - core_done arriving in the same cycle as the timeout wins: normal result, no abort.
- Without macro: no counter; core_abort is tied to 0; WAIT waits indefinitely.

Decomposition:
- Package moddiv_pkg:
  - MODDIV_W=258.
  - State enum type (IDLE, START, WAIT, RESP).
  - Default TIMEOUT constant.
  - Shared with the core and its bench.
- Sub-module rr_arbiter:
  - Parameterised N_REQ.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Combinational.

Test Plan:
- Single request: requester 0 with a=3, b=5, p=11; core model returns 9.
  -> req_ready[0] in the first cycle; core_start one cycle later; rsp_valid[0] with rsp_data=9, rsp_err=0.
- Inversion case: b=1, a=3, p=11 -> rsp_data=4. Also the 256-bit vector a=421DEBD6…7FEDD43D, b=0680512B…E46E09A2, p=8542D69E…08F1DFC3 -> rsp_data times a mod p equals b.
- All four requesters valid continuously -> grant order 0,1,2,3,0. Each rsp_valid only on the granted bit. rsp_ready withheld 5 cycles -> rsp_data held stable.
- a=0 or p=10 -> no core_start; rsp_err=1, rsp_data=0 one cycle after acceptance.
- rst asserted during WAIT -> next cycle all outputs 0, state IDLE. After release, a fresh request on requester 2 is served normally.
- MODDIV_ARB_TIMEOUT_EN with TIMEOUT=16 and the core model never asserting done -> core_abort pulse after 16 WAIT cycles, then rsp_err=1. Second run: core_done on the same cycle as the timeout -> normal result, no abort.
